// File: rtl/tiled_matmul_seq_if.sv
// tiled_matmul_seq_if
//   Bus bundle between the tiled matrix-multiply engine and its tile memory.
//   Read side : ren/raddr from the engine, rdata/rready from memory.
//               A word moves on every cycle with ren && rready.
//   Write side: wen/waddr/wdata from the engine, wready from the sink.
//               A word moves on every cycle with wen && wready.
//   raddr = {sel (0=A, 1=B), tile_row, tile_col}
//   waddr = {tile_row, tile_col, word index}
//   Modports: master = engine side, slave = memory/sink side.
interface tiled_matmul_seq_if #(
  parameter int T    = 4,
  parameter int DW   = 16,
  parameter int OW   = 32,
  parameter int IDXW = 1
) ();
  localparam int WIW = $clog2(T * T);

  logic                  ren;
  logic [2*IDXW:0]       raddr;
  logic [DW-1:0]         rdata;
  logic                  rready;
  logic                  wen;
  logic [2*IDXW+WIW-1:0] waddr;
  logic [OW-1:0]         wdata;
  logic                  wready;

  modport master (
    output ren, raddr, wen, waddr, wdata,
    input  rdata, rready, wready
  );

  modport slave (
    input  ren, raddr, wen, waddr, wdata,
    output rdata, rready, wready
  );
endinterface

// File: rtl/tiled_matmul_seq.sv
// tiled_matmul_seq
//   Tiled signed matrix multiply C = A*B for an (n_tiles*T) x (n_tiles*T)
//   matrix. For every output tile C(i,j) (row-major), and for k = 0..n-1,
//   the engine fetches tile A(i,k) then B(k,j) as word-serial bursts, runs
//   T^3 single-multiplier MAC cycles, and after the last k streams the
//   T*T accumulator words out. Accumulation wraps modulo 2^OW.
// Ports
//   clk        rising-edge clock
//   rstn       synchronous active-low reset
//   start      launch request; only a rising edge seen in IDLE launches
//   n_tiles    tiles per side, sampled at launch, clamped to NT_MAX
//   bus        tiled_matmul_seq_if master (tile reads, result writes)
//   all_finish one-cycle pulse after the last result word is accepted
//   state      FSM state for debug
// Assumes T >= 2 so that word and MAC counters have non-zero width.
module tiled_matmul_seq #(
  parameter int T      = 4,
  parameter int DW     = 16,
  parameter int OW     = 32,
  parameter int NT_MAX = 2,
  parameter int IDXW   = 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  input  logic [IDXW:0]             n_tiles,
  tiled_matmul_seq_if.master        bus,
  output logic                      all_finish,
  output logic [2:0]                state
);

  localparam int NW  = T * T;
  localparam int WIW = $clog2(NW);
  localparam int CW  = $clog2(T);
  localparam int PW  = 2 * DW;

  localparam logic [WIW-1:0] LAST_W = WIW'(NW - 1);
  localparam logic [CW-1:0]  LAST_C = CW'(T - 1);
  localparam logic [IDXW:0]  NT_CAP = (IDXW + 1)'(NT_MAX);
  localparam logic [IDXW:0]  ONE_NT = (IDXW + 1)'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    MAC    = 3'd3,
    WRITE  = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic            start_d;
  logic [IDXW:0]   nt;
  logic [IDXW:0]   nt_in;
  logic [IDXW:0]   nt_m1;
  logic [IDXW-1:0] ti, tj, tk;
  logic [WIW-1:0]  ptr, wptr;
  logic            ld_armed;
  logic [CW-1:0]   mr, mc, mm;
  logic            finish_q;

  logic signed [DW-1:0] a_buf [NW];
  logic signed [DW-1:0] b_buf [NW];
  logic signed [OW-1:0] acc   [NW];

  logic                 launch;
  logic                 xfer;
  logic                 load_last;
  logic                 mac_last;
  logic                 k_last;
  logic                 j_last;
  logic                 tile_last;
  logic                 w_acc;
  logic                 w_last;
  logic                 first_term;
  logic [WIW-1:0]       a_idx, b_idx, c_idx;
  logic signed [PW-1:0] prod;
  logic signed [OW-1:0] prod_ext;

  // A launch needs a fresh rising edge of start, so a start held high
  // across DONE does not restart the engine.
  assign launch    = (state_q == IDLE) && start && !start_d;
  assign nt_in     = (n_tiles > NT_CAP) ? NT_CAP : n_tiles;
  assign nt_m1     = nt - ONE_NT;

  assign xfer      = bus.ren && bus.rready;
  assign load_last = xfer && (ptr == LAST_W);
  assign mac_last  = (mr == LAST_C) && (mc == LAST_C) && (mm == LAST_C);
  assign k_last    = ({1'b0, tk} == nt_m1);
  assign j_last    = ({1'b0, tj} == nt_m1);
  assign tile_last = ({1'b0, ti} == nt_m1) && j_last;
  assign w_acc     = bus.wen && bus.wready;
  assign w_last    = w_acc && (wptr == LAST_W);

  // MAC operand selection: A[mr][mm] * B[mm][mc] into acc[mr][mc].
  // The first term of the first k overwrites, so accumulators never need
  // clearing between output tiles.
  assign a_idx      = WIW'(int'(mr) * T + int'(mm));
  assign b_idx      = WIW'(int'(mm) * T + int'(mc));
  assign c_idx      = WIW'(int'(mr) * T + int'(mc));
  assign prod       = PW'(a_buf[a_idx]) * PW'(b_buf[b_idx]);
  assign prod_ext   = OW'(prod);
  assign first_term = (tk == '0) && (mm == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (launch) state_d = (nt_in == '0) ? DONE : LOAD_A;
      LOAD_A:  if (load_last) state_d = LOAD_B;
      LOAD_B:  if (load_last) state_d = MAC;
      MAC:     if (mac_last) state_d = k_last ? WRITE : LOAD_A;
      WRITE:   if (w_last) state_d = tile_last ? DONE : LOAD_A;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs. ren waits one cycle after entering a load state (ld_armed),
  // which gives the mandatory ren-low gap between consecutive bursts.
  always_comb begin
    bus.ren   = 1'b0;
    bus.raddr = '0;
    bus.wen   = 1'b0;
    bus.waddr = '0;
    bus.wdata = '0;
    case (state_q)
      LOAD_A: begin
        bus.ren   = ld_armed;
        bus.raddr = {1'b0, ti, tk};
      end
      LOAD_B: begin
        bus.ren   = ld_armed;
        bus.raddr = {1'b1, tk, tj};
      end
      WRITE: begin
        bus.wen   = 1'b1;
        bus.waddr = {ti, tj, wptr};
        bus.wdata = acc[wptr];
      end
      default: ;
    endcase
  end

  assign all_finish = finish_q;
  assign state      = state_q;

  // Loop counters: word pointers, MAC indices, tile indices.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      start_d  <= 1'b0;
      finish_q <= 1'b0;
      nt       <= '0;
      ti       <= '0;
      tj       <= '0;
      tk       <= '0;
      ptr      <= '0;
      wptr     <= '0;
      ld_armed <= 1'b0;
      mr       <= '0;
      mc       <= '0;
      mm       <= '0;
    end else begin
      start_d  <= start;
      finish_q <= (state_q == DONE);
      case (state_q)
        IDLE: begin
          if (launch) begin
            nt       <= nt_in;
            ti       <= '0;
            tj       <= '0;
            tk       <= '0;
            ptr      <= '0;
            wptr     <= '0;
            ld_armed <= 1'b0;
            mr       <= '0;
            mc       <= '0;
            mm       <= '0;
          end
        end
        LOAD_A, LOAD_B: begin
          if (!ld_armed) begin
            ld_armed <= 1'b1;
            ptr      <= '0;
          end else if (bus.rready) begin
            if (ptr == LAST_W) begin
              ptr      <= '0;
              ld_armed <= 1'b0;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
        end
        MAC: begin
          if (mm != LAST_C) begin
            mm <= mm + 1'b1;
          end else begin
            mm <= '0;
            if (mc != LAST_C) begin
              mc <= mc + 1'b1;
            end else begin
              mc <= '0;
              mr <= (mr == LAST_C) ? '0 : mr + 1'b1;
            end
          end
          if (mac_last) tk <= k_last ? '0 : tk + 1'b1;
        end
        WRITE: begin
          if (bus.wready) begin
            if (wptr == LAST_W) begin
              wptr <= '0;
              if (j_last) begin
                tj <= '0;
                ti <= ti + 1'b1;
              end else begin
                tj <= tj + 1'b1;
              end
            end else begin
              wptr <= wptr + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Tile buffers are plain storage and deliberately not reset.
  always_ff @(posedge clk) begin
    if (xfer) begin
      if (state_q == LOAD_A) a_buf[ptr] <= bus.rdata;
      else                   b_buf[ptr] <= bus.rdata;
    end
  end

  // Accumulators, one product per MAC cycle, wrapping at OW bits.
  always_ff @(posedge clk) begin
    if (state_q == MAC) begin
      acc[c_idx] <= first_term ? prod_ext : acc[c_idx] + prod_ext;
    end
  end

endmodule
